// File: rtl/const_tie_array.sv
// Programmable constant-tie array: NUM_CH registered static controls plus one/zero rails.
// Latency: load sampled on edge k -> const_out updates on edge k+1; shift_out/bit_cnt update every shift edge.
// Backpressure: none; inputs are sampled every cycle and ignored while committing or locked.
//
// Ports:
//   clk, resetn             block clock, asynchronous active-low reset
//   shift_en, shift_data    serial programming of the shadow register, MSB-first
//   load                    commit request (single-cycle pulse)
//   lock                    sticky request to freeze the configuration (only when LOCK_EN=1)
//   const_out               programmable constants, change only on commit or reset
//   one, zero               constant rails
//   shift_out               bit shifted out of the shadow MSB, for daisy-chaining
//   bit_cnt                 bits shifted since last load, saturates at NUM_CH
//   load_err                sticky: most recent load had the wrong bit count
//   locked                  configuration frozen until reset
module const_tie_array #(
   parameter int                NUM_CH      = 8,
   parameter logic [NUM_CH-1:0] DEFAULT_VAL = '0,
   parameter bit                LOCK_EN     = 1'b1,
   parameter int                CNT_W       = $clog2(NUM_CH + 1)
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              shift_en,
   input  logic              shift_data,
   input  logic              load,
   input  logic              lock,
   output logic [NUM_CH-1:0] const_out,
   output logic              one,
   output logic              zero,
   output logic              shift_out,
   output logic [CNT_W-1:0]  bit_cnt,
   output logic              load_err,
   output logic              locked
);

   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_CH);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      COMMIT = 2'd2,
      LOCKED = 2'd3
   } state_t;

   state_t state, state_nxt;

   logic [NUM_CH-1:0] shadow, shadow_nxt;
   logic [NUM_CH-1:0] active, active_nxt;
   logic              shift_out_nxt;
   logic [CNT_W-1:0]  bit_cnt_nxt;
   logic              load_err_nxt;
   logic              locked_nxt;

   logic lock_req;
   logic cnt_full;

   // With LOCK_EN=0 the lock input is simply never seen.
   assign lock_req = LOCK_EN && lock;
   assign cnt_full = (bit_cnt == FULL_CNT);

   // ---------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ---------------------------------------------------------------
   // Next-state logic: load beats lock, lock beats shift
   // ---------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, SHIFT: begin
            if (load) begin
               state_nxt = cnt_full ? COMMIT : IDLE;
            end else if (lock_req) begin
               state_nxt = LOCKED;
            end else if (shift_en) begin
               state_nxt = SHIFT;
            end
         end
         COMMIT:  state_nxt = IDLE;
         LOCKED:  state_nxt = LOCKED;
         default: state_nxt = IDLE;
      endcase
   end

   // ---------------------------------------------------------------
   // Datapath / output next-values
   // ---------------------------------------------------------------
   always_comb begin
      shadow_nxt    = shadow;
      active_nxt    = active;
      shift_out_nxt = shift_out;
      bit_cnt_nxt   = bit_cnt;
      load_err_nxt  = load_err;
      locked_nxt    = locked;
      case (state)
         IDLE, SHIFT: begin
            if (load) begin
               bit_cnt_nxt = '0;
               if (cnt_full) begin
                  load_err_nxt = 1'b0;
               end else begin
                  // Short load: throw away the partial pattern so the next
                  // shift sequence starts from what is actually driving out.
                  load_err_nxt = 1'b1;
                  shadow_nxt   = active;
               end
            end else if (lock_req) begin
               locked_nxt  = 1'b1;
               shadow_nxt  = active;
               bit_cnt_nxt = '0;
            end else if (shift_en) begin
               shadow_nxt    = {shadow[NUM_CH-2:0], shift_data};
               shift_out_nxt = shadow[NUM_CH-1];
               if (!cnt_full) begin
                  bit_cnt_nxt = bit_cnt + 1'b1;
               end
            end
         end
         COMMIT: begin
            active_nxt = shadow;
         end
         default: ;
      endcase
   end

   // ---------------------------------------------------------------
   // Datapath registers
   // ---------------------------------------------------------------
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         shadow    <= DEFAULT_VAL;
         active    <= DEFAULT_VAL;
         shift_out <= 1'b0;
         bit_cnt   <= '0;
         load_err  <= 1'b0;
         locked    <= 1'b0;
      end else begin
         shadow    <= shadow_nxt;
         active    <= active_nxt;
         shift_out <= shift_out_nxt;
         bit_cnt   <= bit_cnt_nxt;
         load_err  <= load_err_nxt;
         locked    <= locked_nxt;
      end
   end

   // Rails are real flops so they look like every other static control
   // to downstream I/O cells; their value never changes outside reset.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         one  <= 1'b1;
         zero <= 1'b0;
      end else begin
         one  <= 1'b1;
         zero <= 1'b0;
      end
   end

   assign const_out = active;

endmodule
